traffic_controller: RTL and testbench

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

---
 rtl/traffic_controller_pkg.sv | 45 ++++
 rtl/traffic_controller_lane.sv | 58 +++++
 rtl/traffic_controller.sv | 62 ++++++
 tb/tb_traffic_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_controller_pkg.sv
// Shared game constants for the traffic lanes: grid size, lane rows, base periods and directions.
// Everything lane-specific is computed from a lane index so sub-modules stay generic.
package traffic_controller_pkg;

   localparam int GRID_COLS     = 20;
   localparam int GRID_ROWS     = 15;
   localparam int NUM_LANES     = 6;
   localparam int CARS_PER_LANE = 4;
   localparam logic [2:0] MAX_LEVEL = 3'd7;

   typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;

   // Lane 0 sits three rows above the bottom edge; lanes climb two rows at a time.
   function automatic logic [3:0] lane_row(input int lane, input int rows);
      return 4'(rows - 3 - 2 * lane);
   endfunction

   function automatic logic [3:0] base_period(input int lane);
      case (lane)
         0:       return 4'd8;
         1:       return 4'd6;
         2:       return 4'd7;
         3:       return 4'd5;
         4:       return 4'd9;
         default: return 4'd4;
      endcase
   endfunction

   function automatic dir_e lane_dir(input int lane);
      return ((lane % 2) == 0) ? DIR_RIGHT : DIR_LEFT;
   endfunction

   // Higher levels shorten every lane's period, never below one tick.
   function automatic logic [3:0] lane_period(input int lane, input logic [2:0] lvl);
      int p;
      p = int'(base_period(lane)) - int'(lvl);
      if (p < 1) p = 1;
      return 4'(p);
   endfunction

   function automatic logic [4:0] start_x(input int lane, input int k, input int cols);
      return 5'((5 * k + 2 * lane) % cols);
   endfunction

endpackage

// File: rtl/traffic_controller_lane.sv
// One lane of four cars: a tick-driven step counter and the wrapping x positions it advances.
module lane_mover
   import traffic_controller_pkg::*;
#(
   parameter int LANE = 0,
   parameter int COLS = GRID_COLS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        clear,
   input  logic [3:0]  period,
   output logic [19:0] x_pos
);

   localparam logic [4:0] X_MAX = 5'(COLS - 1);
   localparam dir_e       DIR   = lane_dir(LANE);

   logic [3:0]      step_cnt;
   logic            step;
   logic            advance;
   logic [3:0][4:0] xs;
   logic [3:0][4:0] xs_next;

   assign step    = tick && (step_cnt == period - 4'd1);
   assign advance = step && !clear;
   assign x_pos   = xs;

   // A level change restarts the lane's period from scratch, winning over any tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         step_cnt <= '0;
      else if (clear)
         step_cnt <= '0;
      else if (tick)
         step_cnt <= step ? 4'd0 : step_cnt + 4'd1;
   end

   always_comb begin
      xs_next = xs;
      for (int k = 0; k < CARS_PER_LANE; k++) begin
         if (DIR == DIR_RIGHT)
            xs_next[k] = (xs[k] == X_MAX) ? 5'd0 : xs[k] + 5'd1;
         else
            xs_next[k] = (xs[k] == 5'd0) ? X_MAX : xs[k] - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CARS_PER_LANE; k++)
            xs[k] <= start_x(LANE, k, COLS);
      end else if (advance) begin
         xs <= xs_next;
      end
   end

endmodule

// File: rtl/traffic_controller.sv
// Traffic for the frog game: tick prescaler, difficulty level tracking and six lane movers.
module traffic_controller #(
   parameter int TICK_DIV  = 1000000,
   parameter int GRID_COLS = 20,
   parameter int GRID_ROWS = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         freeze,
   input  logic         frog_at_top,
   output logic [119:0] car_x,
   output logic [95:0]  car_y,
   output logic [2:0]   level,
   output logic         level_up
);

   import traffic_controller_pkg::*;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          frog_q;
   logic          bump;

   assign tick = !freeze && (tick_cnt == TICK_LAST);
   assign bump = frog_at_top && !frog_q && (level != MAX_LEVEL);

   // Freeze stalls the prescaler, but a frog arrival still raises the level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         frog_q   <= 1'b0;
         level    <= '0;
         level_up <= 1'b0;
      end else begin
         frog_q   <= frog_at_top;
         level_up <= bump;
         if (bump)
            level <= level + 3'd1;
         if (!freeze)
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      end
   end

   for (genvar L = 0; L < NUM_LANES; L++) begin : g_lane
      lane_mover #(
         .LANE (L),
         .COLS (GRID_COLS)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .tick   (tick),
         .clear  (bump),
         .period (lane_period(L, level)),
         .x_pos  (car_x[20*L +: 20])
      );
      assign car_y[16*L +: 16] = {CARS_PER_LANE{lane_row(L, GRID_ROWS)}};
   end

endmodule

// File: tb/tb_traffic_controller.sv
// Checks traffic_controller against a per-car behavioural model plus directed timing points.
module tb_traffic_controller;

   localparam int TICK_DIV = 4;
   localparam int COLS     = 20;
   localparam int BASE [6] = '{8, 6, 7, 5, 9, 4};

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         freeze = 1'b0;
   logic         frog_at_top = 1'b0;
   logic [119:0] car_x;
   logic [95:0]  car_y;
   logic [2:0]   level;
   logic         level_up;

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   int lu_count = 0;

   traffic_controller #(
      .TICK_DIV  (TICK_DIV),
      .GRID_COLS (COLS),
      .GRID_ROWS (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .freeze      (freeze),
      .frog_at_top (frog_at_top),
      .car_x       (car_x),
      .car_y       (car_y),
      .level       (level),
      .level_up    (level_up)
   );

   always #5 clk = ~clk;

   // Reference model: whole-game view, one integer position per car.
   int m_tick;
   int m_step [6];
   int m_x [24];
   int m_level;
   bit m_lu;
   bit m_fprev;

   task automatic model_reset();
      m_tick = 0;
      m_level = 0;
      m_lu = 0;
      m_fprev = 0;
      for (int l = 0; l < 6; l++) begin
         m_step[l] = 0;
         for (int k = 0; k < 4; k++) m_x[4*l+k] = (5*k + 2*l) % COLS;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset();
         cyc = 0;
      end else begin
         bit ticked;
         bit bump;
         int per;
         cyc++;
         ticked = (m_tick == TICK_DIV - 1) && !freeze;
         bump = frog_at_top && !m_fprev && (m_level < 7);
         for (int l = 0; l < 6; l++) begin
            per = BASE[l] - m_level;
            if (per < 1) per = 1;
            if (bump) m_step[l] = 0;
            else if (ticked) begin
               m_step[l]++;
               if (m_step[l] == per) begin
                  m_step[l] = 0;
                  for (int k = 0; k < 4; k++)
                     m_x[4*l+k] = (m_x[4*l+k] + ((l % 2 == 0) ? 1 : COLS - 1)) % COLS;
               end
            end
         end
         if (!freeze) m_tick = (m_tick + 1) % TICK_DIV;
         m_lu = bump;
         if (bump) m_level++;
         m_fprev = frog_at_top;
      end
   end

   function automatic logic [119:0] model_x();
      logic [119:0] v;
      v = '0;
      for (int n = 0; n < 24; n++) v[5*n +: 5] = 5'(m_x[n]);
      return v;
   endfunction

   function automatic logic [95:0] model_y();
      logic [95:0] v;
      v = '0;
      for (int n = 0; n < 24; n++) v[4*n +: 4] = 4'(12 - 2 * (n / 4));
      return v;
   endfunction

   function automatic logic [4:0] get_x(input int n);
      return car_x[5*n +: 5];
   endfunction

   function automatic logic [3:0] get_y(input int n);
      return car_y[4*n +: 4];
   endfunction

   task automatic check_output(input string name, input logic [119:0] act, input logic [119:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check_output("model car_x", car_x, model_x());
         check_output("model car_y", 120'(car_y), 120'(model_y()));
         check_output("model level", 120'(level), 120'(m_level));
         check_output("model level_up", 120'(level_up), 120'(m_lu));
         if (level_up) lu_count++;
      end
   end

   task automatic apply_stimulus(input logic f, input logic fr, input int n);
      freeze = f;
      frog_at_top = fr;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, " car0 x"},  120'(get_x(0)),  120'(0));
      check_output({tag, " car0 y"},  120'(get_y(0)),  120'(12));
      check_output({tag, " car5 x"},  120'(get_x(5)),  120'(7));
      check_output({tag, " car5 y"},  120'(get_y(5)),  120'(10));
      check_output({tag, " car23 x"}, 120'(get_x(23)), 120'(5));
      check_output({tag, " car23 y"}, 120'(get_y(23)), 120'(2));
      check_output({tag, " level"},   120'(level),     120'(0));
      check_output({tag, " level_up"}, 120'(level_up), 120'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [119:0] snap;
      logic [4:0]   x0;

      #1 reset = 1'b1;
      #2 check_reset_values("por");
      @(negedge clk);
      reset = 1'b0;

      // Lane timing and wrap points from reset with TICK_DIV=4.
      wait_cycle(15);  check_output("lane5 hold @15", 120'(get_x(20)), 120'(10));
      wait_cycle(16);  check_output("lane5 step @16", 120'(get_x(20)), 120'(9));
      wait_cycle(24);  check_output("lane1 car4 @24", 120'(get_x(4)), 120'(1));
      wait_cycle(31);  check_output("lane0 hold @31", 120'(get_x(0)), 120'(0));
      wait_cycle(32);  check_output("lane0 step @32", 120'(get_x(0)), 120'(1));
      wait_cycle(48);  check_output("lane1 car4 @48", 120'(get_x(4)), 120'(0));
      wait_cycle(72);  check_output("lane1 wrap @72", 120'(get_x(4)), 120'(19));
      wait_cycle(128); check_output("lane0 car3 @128", 120'(get_x(3)), 120'(19));
      wait_cycle(160); check_output("lane0 wrap @160", 120'(get_x(3)), 120'(0));

      // Long freeze with a frog arrival in the middle.
      snap = car_x;
      lu_count = 0;
      apply_stimulus(1'b1, 1'b0, 50);
      apply_stimulus(1'b1, 1'b1, 2);
      apply_stimulus(1'b1, 1'b0, 48);
      check_output("freeze car_x", car_x, snap);
      check_output("freeze level", 120'(level), 120'(1));
      check_output("freeze level_up count", 120'(lu_count), 120'(1));
      apply_stimulus(1'b0, 1'b0, 1);

      // Eight frog arrivals saturate the level at 7.
      do_reset();
      lu_count = 0;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, 1'b1, 2);
         apply_stimulus(1'b0, 1'b0, 2);
      end
      check_output("sat level", 120'(level), 120'(7));
      check_output("sat level_up count", 120'(lu_count), 120'(7));
      x0 = get_x(20);
      apply_stimulus(1'b0, 1'b0, 4);
      check_output("lane5 period 1", 120'(get_x(20)), 120'((int'(x0) + 19) % 20));

      // Asynchronous reset in the middle of a period at level 3.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 1'b1, 2);
         apply_stimulus(1'b0, 1'b0, 2);
      end
      apply_stimulus(1'b0, 1'b0, 13);
      check_output("pre-reset level", 120'(level), 120'(3));
      do_reset();

      // Random freeze / frog traffic with rare asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b1;
            #1 reset = 1'b0;
         end
         apply_stimulus($urandom_range(0, 9) == 0,
                        ($urandom_range(0, 5) == 0) ? ~frog_at_top : frog_at_top, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
